// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register file.
//   byte_lanes(width) : number of 8-bit lanes in a data word
//   addr_width(depth) : address width needed to index depth registers
//   ZERO_REG          : index of the hardwired-zero register
package regfile_pkg;

    localparam int unsigned ZERO_REG = 0;

    // Byte lanes per data word (width is a multiple of 8).
    function automatic int unsigned byte_lanes(input int unsigned width);
        return width / 8;
    endfunction

    // Address width for a register file of the given depth (at least 1 bit).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_group_param.sv
// One WIDTH-bit register with per-byte write enables and a synchronous clear.
//   clk : rising-edge clock
//   clr : synchronous clear, active-high, wins over be
//   be  : byte-lane write enables
//   d   : write data
//   q   : stored value
module reg_group_param
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned NB    = byte_lanes(WIDTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [NB-1:0]    be,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Lanes without an enable hold their value.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (be[b]) begin
                    q[8*b +: 8] <= d[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_param.sv
// DEPTH x WIDTH register file: two combinational read ports, one byte-masked
// write port, register 0 hardwired to zero, optional write-to-read bypass and
// a per-register busy scoreboard (reserve at issue, release on writeback).
//   clk, rst           : clock, synchronous active-high reset
//   we/waddr/wbe/wdata : writeback port
//   raddrN/rdataN      : read ports (combinational data)
//   rsN_busy           : register at raddrN is reserved (combinational)
//   rsv_en/rsv_addr    : reservation port
//   busy_cnt           : registered count of busy registers
//   wr_unrsv           : registered pulse, previous write hit a non-busy register
module regfile_param
    import regfile_pkg::*;
#(
    parameter  int unsigned WIDTH  = 32,
    parameter  int unsigned DEPTH  = 32,
    parameter  bit          BYPASS = 1'b1,
    localparam int unsigned ADDR_W = addr_width(DEPTH),
    localparam int unsigned NB     = byte_lanes(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [NB-1:0]     wbe,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    output logic              rs1_busy,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2,
    output logic              rs2_busy,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [ADDR_W:0]   busy_cnt,
    output logic              wr_unrsv
);

    localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_REG);

    // Address names a real, writable register (not r0, not past DEPTH).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != ZERO_A) && ({1'b0, a} < DEPTH_W);
    endfunction

    // Replace the enabled byte lanes of old_v with new_v.
    function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_v,
                                                    input logic [WIDTH-1:0] new_v,
                                                    input logic [NB-1:0]    be);
        logic [WIDTH-1:0] r;
        r = old_v;
        for (int unsigned b = 0; b < NB; b++) begin
            if (be[b]) begin
                r[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return r;
    endfunction

    logic                 wr_ok;
    logic                 rsv_ok;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH-1:0]     busy;
    logic [DEPTH-1:0]     busy_nxt;
    logic [ADDR_W:0]      cnt_nxt;

    assign wr_ok  = we && addr_ok(waddr);
    assign rsv_ok = rsv_en && addr_ok(rsv_addr);

    // Storage: r0 is a constant, every other entry is a byte-enabled register.
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign mem[i] = '0;
        end else begin : g_store
            reg_group_param #(
                .WIDTH (WIDTH)
            ) u_reg (
                .clk (clk),
                .clr (rst),
                .be  ((wr_ok && (waddr == ADDR_W'(i))) ? wbe : '0),
                .d   (wdata),
                .q   (mem[i])
            );
        end
    end

    // Next busy vector: writeback releases, then a same-cycle reservation wins.
    always_comb begin
        busy_nxt = busy;
        if (wr_ok) begin
            busy_nxt[waddr] = 1'b0;
        end
        if (rsv_ok) begin
            busy_nxt[rsv_addr] = 1'b1;
        end
        busy_nxt[ZERO_REG] = 1'b0;
    end

    // Popcount of the next busy vector.
    always_comb begin
        cnt_nxt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
        end
    end

    // Scoreboard state and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
            wr_unrsv <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            wr_unrsv <= wr_ok && !busy[waddr];
        end
    end

    // Read port 1 with optional bypass of the in-flight write.
    always_comb begin
        rdata1   = '0;
        rs1_busy = 1'b0;
        if (addr_ok(raddr1)) begin
            rdata1   = mem[raddr1];
            rs1_busy = busy[raddr1];
            if (BYPASS && wr_ok && (waddr == raddr1)) begin
                rdata1   = lane_merge(mem[raddr1], wdata, wbe);
                rs1_busy = 1'b0;
            end
        end
    end

    // Read port 2 with optional bypass of the in-flight write.
    always_comb begin
        rdata2   = '0;
        rs2_busy = 1'b0;
        if (addr_ok(raddr2)) begin
            rdata2   = mem[raddr2];
            rs2_busy = busy[raddr2];
            if (BYPASS && wr_ok && (waddr == raddr2)) begin
                rdata2   = lane_merge(mem[raddr2], wdata, wbe);
                rs2_busy = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: instance A (DEPTH=32, bypass) and instance B
// (DEPTH=20, no bypass) share stimulus; a reference model feeds a queue of
// expected outputs that is drained against both instances.
module tb_regfile_param;

    localparam int unsigned DA = 32;
    localparam int unsigned DB = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        rsv_en;
    logic [4:0]  rsv_addr;

    logic [31:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
    logic        a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;
    logic [5:0]  a_busy_cnt, b_busy_cnt;
    logic        a_wr_unrsv, b_wr_unrsv;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    // Reference model state
    logic [31:0] ma [32];
    logic [31:0] mb [32];
    logic [31:0] busy_a, busy_b;
    logic        unr_a, unr_b;

    always #5 clk = ~clk;

    regfile_param #(.WIDTH(32), .DEPTH(DA), .BYPASS(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
        .raddr1(raddr1), .rdata1(a_rdata1), .rs1_busy(a_rs1_busy),
        .raddr2(raddr2), .rdata2(a_rdata2), .rs2_busy(a_rs2_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_cnt(a_busy_cnt), .wr_unrsv(a_wr_unrsv)
    );

    regfile_param #(.WIDTH(32), .DEPTH(DB), .BYPASS(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
        .raddr1(raddr1), .rdata1(b_rdata1), .rs1_busy(b_rs1_busy),
        .raddr2(raddr2), .rdata2(b_rdata2), .rs2_busy(b_rs2_busy),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .busy_cnt(b_busy_cnt), .wr_unrsv(b_wr_unrsv)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_rd(input bit is_b, input logic [4:0] a);
        int d;
        logic [31:0] v;
        d = is_b ? int'(DB) : int'(DA);
        if (a == 5'd0 || int'(a) >= d) return 32'h0;
        v = is_b ? mb[a] : ma[a];
        if (!is_b && we && waddr == a) v = merge(v, wdata, wbe);
        return v;
    endfunction

    function automatic logic exp_busy(input bit is_b, input logic [4:0] a);
        int d;
        d = is_b ? int'(DB) : int'(DA);
        if (a == 5'd0 || int'(a) >= d) return 1'b0;
        if (!is_b && we && waddr == a) return 1'b0;
        return is_b ? busy_b[a] : busy_a[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            ma[i] = 32'h0;
            mb[i] = 32'h0;
        end
        busy_a = 32'h0;
        busy_b = 32'h0;
        unr_a  = 1'b0;
        unr_b  = 1'b0;
    endtask

    task automatic model_edge(input bit is_b);
        int          d;
        logic [31:0] bz;
        bit          wok, rok, unr;
        d   = is_b ? int'(DB) : int'(DA);
        bz  = is_b ? busy_b : busy_a;
        wok = we && waddr != 5'd0 && int'(waddr) < d;
        rok = rsv_en && rsv_addr != 5'd0 && int'(rsv_addr) < d;
        unr = wok && !bz[waddr];
        if (wok) begin
            if (is_b) mb[waddr] = merge(mb[waddr], wdata, wbe);
            else      ma[waddr] = merge(ma[waddr], wdata, wbe);
            bz[waddr] = 1'b0;
        end
        if (rok) bz[rsv_addr] = 1'b1;
        if (is_b) begin
            busy_b = bz;
            unr_b  = unr;
        end else begin
            busy_a = bz;
            unr_a  = unr;
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_underflow", 32'h1, 32'h0);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, got, e.val);
        end
    endtask

    task automatic push_comb();
        push("a_rdata1", exp_rd(1'b0, raddr1));
        push("a_rs1_busy", 32'(exp_busy(1'b0, raddr1)));
        push("a_rdata2", exp_rd(1'b0, raddr2));
        push("a_rs2_busy", 32'(exp_busy(1'b0, raddr2)));
        push("b_rdata1", exp_rd(1'b1, raddr1));
        push("b_rs1_busy", 32'(exp_busy(1'b1, raddr1)));
        push("b_rdata2", exp_rd(1'b1, raddr2));
        push("b_rs2_busy", 32'(exp_busy(1'b1, raddr2)));
    endtask

    task automatic pop_comb();
        pop_check(a_rdata1);
        pop_check(32'(a_rs1_busy));
        pop_check(a_rdata2);
        pop_check(32'(a_rs2_busy));
        pop_check(b_rdata1);
        pop_check(32'(b_rs1_busy));
        pop_check(b_rdata2);
        pop_check(32'(b_rs2_busy));
    endtask

    task automatic push_reg();
        push("a_busy_cnt", 32'($countones(busy_a)));
        push("a_wr_unrsv", 32'(unr_a));
        push("b_busy_cnt", 32'($countones(busy_b)));
        push("b_wr_unrsv", 32'(unr_b));
    endtask

    task automatic pop_reg();
        pop_check(32'(a_busy_cnt));
        pop_check(32'(a_wr_unrsv));
        pop_check(32'(b_busy_cnt));
        pop_check(32'(b_wr_unrsv));
    endtask

    // Drive inputs at the falling edge and check the combinational outputs.
    task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic rv, input logic [4:0] ra);
        @(negedge clk);
        rst = r; we = w; waddr = wa; wbe = be; wdata = wd;
        raddr1 = r1; raddr2 = r2; rsv_en = rv; rsv_addr = ra;
        push_comb();
        #1;
        pop_comb();
    endtask

    // Take the rising edge, advance the model and check the registered outputs.
    task automatic edge_step();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            model_edge(1'b0);
            model_edge(1'b1);
        end
        push_reg();
        #1;
        pop_reg();
    endtask

    task automatic cycle(input logic r, input logic w, input logic [4:0] wa,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic rv, input logic [4:0] ra);
        drive(r, w, wa, be, wd, r1, r2, rv, ra);
        edge_step();
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wbe = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; rsv_en = 1'b0; rsv_addr = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        push_reg();
        pop_reg();

        // Post-reset: every address reads zero and nothing is busy
        for (int i = 0; i < 32; i++) begin
            cycle(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'(i), 5'(31 - i), 1'b0, 5'd0);
        end

        // Byte-masked writes and the zero register
        cycle(1'b0, 1'b1, 5'd5, 4'hF, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0, 5'd0);
        cycle(1'b0, 1'b1, 5'd5, 4'b0010, 32'h0000AA00, 5'd5, 5'd0, 1'b0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
        check("r5_merge", a_rdata1, 32'hDEADAAEF);
        check("r5_merge_b", b_rdata2, 32'hDEADAAEF);
        cycle(1'b0, 1'b1, 5'd0, 4'hF, 32'hFFFFFFFF, 5'd0, 5'd5, 1'b0, 5'd0);
        check("r0_zero", a_rdata1, 32'h0);
        check("r0_no_pulse", 32'(a_wr_unrsv), 32'h0);

        // Same-cycle bypass (A) versus stored value (B)
        cycle(1'b0, 1'b1, 5'd7, 4'hF, 32'h11111111, 5'd0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 1'b1, 5'd7, 4'hF, 32'h12345678, 5'd7, 5'd0, 1'b0, 5'd0);
        check("bypass_a", a_rdata1, 32'h12345678);
        check("nobypass_b", b_rdata1, 32'h11111111);
        edge_step();

        // Reservation, release, and same-cycle reserve+write
        cycle(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd3, 5'd0, 1'b1, 5'd3);
        check("r3_busy", 32'(a_rs1_busy), 32'h1);
        check("cnt_one", 32'(a_busy_cnt), 32'h1);
        cycle(1'b0, 1'b1, 5'd3, 4'hF, 32'hCAFE0003, 5'd3, 5'd0, 1'b0, 5'd0);
        check("cnt_zero", 32'(a_busy_cnt), 32'h0);
        check("r3_no_pulse", 32'(a_wr_unrsv), 32'h0);
        cycle(1'b0, 1'b1, 5'd4, 4'hF, 32'h00000004, 5'd4, 5'd0, 1'b1, 5'd4);
        cycle(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd4, 5'd3, 1'b0, 5'd0);
        check("r4_stays_busy", 32'(a_rs1_busy), 32'h1);

        // Unreserved write pulses for exactly one cycle
        cycle(1'b0, 1'b1, 5'd9, 4'hF, 32'h99999999, 5'd9, 5'd0, 1'b0, 5'd0);
        check("r9_pulse", 32'(a_wr_unrsv), 32'h1);
        cycle(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd9, 5'd0, 1'b0, 5'd0);
        check("r9_pulse_end", 32'(a_wr_unrsv), 32'h0);

        // Reset has priority over pending writes and reservations
        for (int i = 1; i <= 4; i++) begin
            cycle(1'b0, 1'b1, 5'(i), 4'hF, 32'hA0A0A0A0 + 32'(i), 5'(i), 5'd0, 1'b1, 5'(i));
        end
        cycle(1'b1, 1'b1, 5'd2, 4'hF, 32'hFFFF0000, 5'd1, 5'd2, 1'b1, 5'd6);
        check("rst_cnt", 32'(a_busy_cnt), 32'h0);
        cycle(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0);
        check("rst_rd1", a_rdata1, 32'h0);
        check("rst_rd2", a_rdata2, 32'h0);

        // Out-of-range address on the DEPTH=20 instance
        cycle(1'b0, 1'b1, 5'd25, 4'hF, 32'h25252525, 5'd25, 5'd0, 1'b1, 5'd25);
        check("oor_no_pulse_b", 32'(b_wr_unrsv), 32'h0);
        check("oor_cnt_b", 32'(b_busy_cnt), 32'h0);
        cycle(1'b0, 1'b0, 5'd0, 4'h0, 32'h0, 5'd25, 5'd0, 1'b0, 5'd0);
        check("oor_read_b", b_rdata1, 32'h0);
        check("in_range_a", a_rdata1, 32'h25252525);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            cycle(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), 4'($urandom), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
